// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state encoding and parameter helpers for the FIFO read-side serializer.
package fifo_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    function automatic int calc_ratio(input int w, input int ow);
        return w / ow;
    endfunction

    function automatic int calc_cnt_w(input int w, input int ow);
        return $clog2(w / ow);
    endfunction

    function automatic bit params_ok(input int w, input int ow);
        return ow > 0 && w % ow == 0 && w / ow >= 2;
    endfunction

endpackage

// File: rtl/fifo_rd_serializer_word_shifter.sv
// word_shifter: parallel-load shift register emitting out_width chunks in msb_first order,
// with a chunk counter whose terminal value flags the final chunk of the word.
module word_shifter
    import fifo_pkg::*;
#(
    parameter int width     = 32,
    parameter int out_width = 8,
    parameter bit msb_first = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 advance,
    input  logic [width-1:0]     load_data,
    output logic [out_width-1:0] chunk,
    output logic                 last
);

    localparam int ratio = calc_ratio(width, out_width);
    localparam int cw    = calc_cnt_w(width, out_width);
    localparam logic [cw-1:0] cnt_max = cw'(ratio - 1);

    logic [width-1:0] sr;
    logic [cw-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= load_data;
            cnt <= '0;
        end else if (advance) begin
            sr  <= msb_first ? sr << out_width : sr >> out_width;
            cnt <= last ? '0 : cnt + cw'(1);
        end
    end

    assign chunk = msb_first ? sr[width-1 -: out_width] : sr[out_width-1:0];
    assign last  = cnt == cnt_max;

endmodule

// File: rtl/fifo_rd_serializer.sv
// fifo_rd_serializer: pops FIFO words and streams them as out_width chunks on a valid/ready link,
// prefetching one word so a non-empty FIFO yields back-to-back chunks.
module fifo_rd_serializer
    import fifo_pkg::*;
#(
    parameter int width     = 32,
    parameter int out_width = 8,
    parameter bit msb_first = 1'b1
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [width-1:0]     fifo_rdata,
    output logic [out_width-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy
);

    if (!params_ok(width, out_width)) begin : g_param_check
        $error("fifo_rd_serializer: width must be a multiple of out_width with ratio >= 2");
    end

    state_t           state, state_nx;
    logic             data_vld, pf_full, rd_en_nx;
    logic             pend, slot_free, xfer, end_word, sh_last, load;
    logic [width-1:0] pf_data, load_data;

    assign out_valid = state == SEND;
    assign xfer      = out_valid && out_ready;
    assign end_word  = xfer && sh_last;
    assign out_last  = out_valid && sh_last;
    // data_vld marks the cycle fifo_rdata carries the word requested one cycle earlier
    assign pend      = fifo_rd_en || data_vld;
    assign slot_free = state == IDLE || (state == SEND && !pf_full);
    assign rd_en_nx  = !fifo_empty && !pend && slot_free;
    assign busy      = state != IDLE || pf_full || pend;

    always_comb begin
        load      = (state == FETCH && data_vld) || (end_word && (pf_full || data_vld));
        load_data = pf_full ? pf_data : fifo_rdata;
        state_nx  = state;
        if (state == IDLE && rd_en_nx) state_nx = FETCH;
        else if (state == FETCH && data_vld) state_nx = SEND;
        else if (end_word) state_nx = load ? SEND : (pend || rd_en_nx) ? FETCH : IDLE;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            data_vld   <= 1'b0;
            pf_full    <= 1'b0;
            pf_data    <= '0;
        end else begin
            state      <= state_nx;
            fifo_rd_en <= rd_en_nx;
            data_vld   <= fifo_rd_en;
            if (state == SEND && data_vld && !end_word) begin
                pf_full <= 1'b1;
                pf_data <= fifo_rdata;
            end else if (end_word) begin
                pf_full <= 1'b0;
            end
        end
    end

    word_shifter #(
        .width    (width),
        .out_width(out_width),
        .msb_first(msb_first)
    ) u_shifter (
        .clk      (sys_clk),
        .rst_n    (rst_n),
        .load     (load),
        .advance  (xfer),
        .load_data(load_data),
        .chunk    (out_data),
        .last     (sh_last)
    );

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// tb_fifo_rd_serializer: scoreboard bench driving an MSB-first and an LSB-first serializer from one FIFO model.
module tb_fifo_rd_serializer;

    localparam int W  = 32;
    localparam int OW = 8;
    localparam int R  = W / OW;

    typedef struct packed {
        logic          last;
        logic [OW-1:0] m;
        logic [OW-1:0] l;
    } chunk_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          out_ready = 1'b1;
    logic [W-1:0]  fifo_rdata = '0;
    logic          rd_en0, rd_en1, v0, v1, l0, l1, busy0, busy1;
    logic [OW-1:0] d0, d1;
    logic          rd_seen = 1'b0;

    int total = 0, bad = 0, pops = 0, words_popped = 0, done = 0;
    logic [W-1:0] fifo_q[$];
    chunk_t       expq[$];

    always #5 clk = ~clk;

    fifo_rd_serializer #(.width(W), .out_width(OW), .msb_first(1'b1)) u_msb (
        .sys_clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en0),
        .fifo_rdata(fifo_rdata), .out_data(d0), .out_valid(v0), .out_ready(out_ready),
        .out_last(l0), .busy(busy0)
    );

    fifo_rd_serializer #(.width(W), .out_width(OW), .msb_first(1'b0)) u_lsb (
        .sys_clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en1),
        .fifo_rdata(fifo_rdata), .out_data(d1), .out_valid(v1), .out_ready(out_ready),
        .out_last(l1), .busy(busy1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO with one-cycle read latency; each pop enqueues the chunks the spec says the word yields
    always @(posedge clk) begin
        if (rst_n && rd_seen) begin
            check("pop_while_empty", fifo_q.size() != 0, 1);
            if (fifo_q.size() != 0) begin
                logic [W-1:0] w;
                w = fifo_q.pop_front();
                fifo_rdata <= w;
                pops++;
                words_popped++;
                for (int i = 0; i < R; i++)
                    expq.push_back('{last: i == R - 1, m: OW'(w >> (OW * (R - 1 - i))), l: OW'(w >> (OW * i))});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("valid_pair", v1, v0);
            if (v0) begin
                if (expq.size() == 0) begin
                    check("unexpected_chunk", 1, 0);
                end else begin
                    check("msb_data", d0, expq[0].m);
                    check("lsb_data", d1, expq[0].l);
                    check("msb_last", l0, expq[0].last);
                    check("lsb_last", l1, expq[0].last);
                    if (out_ready) begin
                        if (expq[0].last) done++;
                        void'(expq.pop_front());
                    end
                end
            end
            check("held_le_2", (words_popped - done) <= 2, 1);
        end
        rd_seen    = rd_en0 && rst_n;
        fifo_empty = fifo_q.size() == 0;
    end

    task automatic push(input logic [W-1:0] w);
        fifo_q.push_back(w);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        @(negedge clk);
        while (!v0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", v0, 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((fifo_q.size() != 0 || expq.size() != 0 || busy0 || busy1) && n < budget);
        check("drain_idle", fifo_q.size() == 0 && expq.size() == 0 && !busy0 && !busy1, 1);
    endtask

    initial begin
        int p0;
        // reset held with a non-empty FIFO, then single word with latency checks
        push(32'hA1B2C3D4);
        repeat (4) begin
            @(negedge clk);
            check("rst_rd_en", rd_en0, 0);
            check("rst_valid", v0, 0);
            check("rst_data", d0, 0);
            check("rst_busy", busy0, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); check("rd_en_before", rd_en0, 0);
        @(negedge clk); check("rd_en_first", rd_en0, 1);
        @(negedge clk); check("latency_n1", v0, 0);
        @(negedge clk); check("latency_n2", v0, 1);
        check("first_msb", d0, 8'hA1);
        check("first_lsb", d1, 8'hD4);
        drain(50);

        // back-to-back words must stream without a gap
        @(posedge clk); #1;
        p0 = pops;
        push(32'h00010203); push(32'h04050607); push(32'h08090A0B);
        wait_valid(20);
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            check("no_gap", v0, 1);
        end
        drain(50);
        check("b2b_pops", pops - p0, 3);

        // backpressure: only shift register and prefetch buffer may fill
        @(posedge clk); #1;
        out_ready = 1'b0;
        p0 = pops;
        push(32'h10111213); push(32'h20212223); push(32'h30313233); push(32'h40414243);
        wait_valid(20);
        repeat (10) begin
            @(negedge clk);
            check("stall_valid", v0, 1);
        end
        check("stall_pops", pops - p0, 2);
        @(posedge clk); #1 out_ready = 1'b1;
        drain(100);
        check("stall_total_pops", pops - p0, 4);

        // async reset mid-word discards the held word
        @(posedge clk); #1 push(32'hDEADBEEF);
        wait_valid(20);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", v0, 0);
        check("async_data", d0, 0);
        check("async_last", l0, 0);
        check("async_busy", busy0, 0);
        check("async_rd_en", rd_en0, 0);
        expq.delete();
        fifo_q.delete();
        words_popped = 0;
        done = 0;
        @(posedge clk); #1 push(32'h11223344);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_valid(20);
        check("post_rst_first", d0, 8'h11);
        drain(50);

        // randomized traffic and backpressure
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            out_ready = $urandom_range(0, 3) != 0;
            if (fifo_q.size() < 6 && $urandom_range(0, 2) == 0) push($urandom);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        drain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation timeout");
    end

endmodule
